// File: rtl/window_stream_gen.sv
// Raster-order pixel stream to zero-padded 3x3 neighbourhood stream.
// Two line buffers plus three taps form a 2*IMG_W+3 byte shift store feeding one registered window per cycle.
module window_stream_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [7:0]                            in_data,
  output logic                                  win_valid,
  output logic [7:0]                            win_1,
  output logic [7:0]                            win_2,
  output logic [7:0]                            win_3,
  output logic [7:0]                            win_4,
  output logic [7:0]                            win_5,
  output logic [7:0]                            win_6,
  output logic [7:0]                            win_7,
  output logic [7:0]                            win_8,
  output logic [7:0]                            win_9,
  output logic [$clog2(IMG_W*IMG_H)-1:0]        win_addr,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic [1:0]                            fsm_state
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int AW   = XW + YW;
  localparam int FW   = $clog2(IMG_W + 1);
  localparam int TAPS = 2 * IMG_W + 3;

  localparam logic [AW-1:0] CTR_OFF    = AW'(IMG_W + 1);
  localparam logic [AW-1:0] PIX_LAST   = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] FLUSH_BASE = AW'(IMG_W * IMG_H - IMG_W - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

  // Input handshake: a pixel transfers on a rising edge where in_valid & in_ready;
  // in_ready is high exactly while in RUN. The window output has no backpressure.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   pix_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [7:0]      taps_q [TAPS];
  logic [7:0]      taps_n [TAPS];
  logic [7:0]      win_n  [9];
  logic            clear, accept, flushing, done, shift, emit;
  logic [7:0]      shift_byte;
  logic [AW-1:0]   center;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic            pad_l, pad_r, pad_t, pad_b;

  assign fsm_state = state_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_n  = state_q;
    clear    = 1'b0;
    accept   = 1'b0;
    flushing = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (pix_cnt == PIX_LAST)) state_n = FLUSH;
      end
      FLUSH: begin
        flushing = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign shift      = accept | flushing;
  assign shift_byte = flushing ? 8'd0 : in_data;
  assign emit       = (accept && (pix_cnt >= CTR_OFF)) || flushing;
  // Center trails the newest pixel by one row plus one; during flush the
  // pixel index has stopped, so the center is rebuilt from the flush count.
  assign center     = flushing ? (FLUSH_BASE + AW'(flush_cnt)) : (pix_cnt - CTR_OFF);
  assign cx         = center[XW-1:0];
  assign cy         = center[AW-1:XW];
  assign pad_l      = (cx == '0);
  assign pad_r      = (cx == XW'(IMG_W - 1));
  assign pad_t      = (cy == '0);
  assign pad_b      = (cy == YW'(IMG_H - 1));

  always_comb begin
    taps_n[0] = shift_byte;
    for (int i = 1; i < TAPS; i++) taps_n[i] = taps_q[i-1];
  end

  // Window k (row r, column c) reads tap (2-r)*IMG_W + (2-c) of the post-shift store.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_n[k] = taps_n[(2 - k / 3) * IMG_W + (2 - k % 3)];
      if ((k / 3 == 0 && pad_t) || (k / 3 == 2 && pad_b) ||
          (k % 3 == 0 && pad_l) || (k % 3 == 2 && pad_r))
        win_n[k] = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pix_cnt    <= '0;
      flush_cnt  <= '0;
      for (int i = 0; i < TAPS; i++) taps_q[i] <= 8'd0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_addr   <= '0;
      win_1      <= 8'd0;
      win_2      <= 8'd0;
      win_3      <= 8'd0;
      win_4      <= 8'd0;
      win_5      <= 8'd0;
      win_6      <= 8'd0;
      win_7      <= 8'd0;
      win_8      <= 8'd0;
      win_9      <= 8'd0;
    end else begin
      state_q    <= state_n;
      win_valid  <= emit;
      frame_done <= done;
      if (clear) begin
        pix_cnt   <= '0;
        flush_cnt <= '0;
        for (int i = 0; i < TAPS; i++) taps_q[i] <= 8'd0;
      end else begin
        if (shift) begin
          for (int i = 0; i < TAPS; i++) taps_q[i] <= taps_n[i];
        end
        if (accept)   pix_cnt   <= pix_cnt + AW'(1);
        if (flushing) flush_cnt <= flush_cnt + FW'(1);
      end
      if (emit) begin
        win_addr <= center;
        win_1    <= win_n[0];
        win_2    <= win_n[1];
        win_3    <= win_n[2];
        win_4    <= win_n[3];
        win_5    <= win_n[4];
        win_6    <= win_n[5];
        win_7    <= win_n[6];
        win_8    <= win_n[7];
        win_9    <= win_n[8];
      end
    end
  end

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen: random frames and input duty checked against a
// 2-D zero-padded neighbourhood model, plus fixed ramp-frame windows.
module tb_window_stream_gen;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int NPIX = W * H;
  localparam int VW   = 84;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, win_valid, busy, frame_done;
  logic [7:0]  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
  logic [11:0] win_addr;
  logic [1:0]  fsm_state;

  window_stream_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .win_valid(win_valid),
    .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4), .win_5(win_5),
    .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_9(win_9),
    .win_addr(win_addr), .busy(busy), .frame_done(frame_done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0]    frame [NPIX];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] got   [NPIX];
  logic [VW-1:0] obs_w;
  logic [VW-1:0] done_tag = '0;
  int            win_cnt = 0;
  int            cyc = 0;
  int            cnt_base = 0;
  int            last_acc_cyc = 0;

  assign obs_w = {win_addr, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9};

  function automatic logic [VW-1:0] pack9(input int addr, input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int i);
    return {12'(addr), 8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  // reference: 3x3 neighbourhood from 2-D coordinates, zero outside the frame
  function automatic logic [VW-1:0] model_win(input int c);
    int x = c % W;
    int y = c / W;
    logic [VW-1:0] v = VW'(c);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int xx = x + dx;
        int yy = y + dy;
        logic [7:0] p = 8'd0;
        if (xx >= 0 && xx < W && yy >= 0 && yy < H) p = frame[yy * W + xx];
        v = (v << 8) | VW'(p);
      end
    end
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  always @(negedge clk) begin
    if (win_valid) begin
      win_cnt <= win_cnt + 1;
      got[win_addr] <= obs_w;
      check("win_pending", VW'(exp_q.size() != 0), VW'(1));
      if (exp_q.size() != 0) check("window", obs_w, exp_q.pop_front());
    end
    if (frame_done) done_tag <= VW'({win_valid, win_addr});
  end

  // driver tasks
  task automatic start_frame(input int ramp);
    for (int i = 0; i < NPIX; i++) frame[i] = ramp ? 8'(i) : 8'($urandom_range(255));
    for (int c = 0; c < NPIX; c++) exp_q.push_back(model_win(c));
    cnt_base = win_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_run", VW'({busy, in_ready, fsm_state}), VW'({1'b1, 1'b1, 2'd1}));
  endtask

  task automatic send_frame(input int duty, input int poke_at, input int abort_at);
    int n = 0;
    int guard = 0;
    while (n < NPIX && guard < 50000) begin
      @(negedge clk);
      if (start) check("poke_ignored", VW'({busy, in_ready, fsm_state}), VW'({1'b1, 1'b1, 2'd1}));
      if (n == abort_at) begin
        in_valid = 1'b0;
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("abort_win", obs_w, '0);
        check("abort_ctrl", VW'({in_ready, win_valid, busy, frame_done, fsm_state}), '0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      start    = (n == poke_at);
      in_valid = ($urandom_range(99) < duty);
      in_data  = in_valid ? frame[n] : 8'($urandom_range(255));
      if (in_valid && in_ready) begin
        n++;
        last_acc_cyc = cyc + 1;
      end
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    check("feed_complete", VW'(n), VW'(NPIX));
  endtask

  task automatic wait_done();
    bit seen = 0;
    int ready_hi = 0;
    int done_cyc = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        done_cyc = cyc;
      end else if (in_ready) ready_hi++;
    end
    check("done_seen", VW'(seen), VW'(1));
    check("flush_ready_low", VW'(ready_hi), VW'(0));
    check("done_latency", VW'(done_cyc - last_acc_cyc), VW'(65));
    @(negedge clk);
    check("win_count", VW'(win_cnt - cnt_base), VW'(NPIX));
    check("queue_empty", VW'(exp_q.size()), VW'(0));
    check("done_on_last", done_tag, VW'({1'b1, 12'hfff}));
    check("idle_after", VW'({busy, in_ready, fsm_state}), VW'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_win", obs_w, '0);
    check("reset_ctrl", VW'({in_ready, win_valid, busy, frame_done, fsm_state}), '0);
    reset = 1'b0;
    @(negedge clk);

    // in_valid while idle must not be accepted
    cnt_base = win_cnt;
    in_valid = 1'b1;
    begin
      int ready_hi = 0;
      for (int k = 0; k < 5; k++) begin
        in_data = 8'($urandom_range(255));
        @(negedge clk);
        if (in_ready || busy || fsm_state != 2'd0) ready_hi++;
      end
      check("idle_no_accept", VW'(ready_hi), VW'(0));
    end
    in_valid = 1'b0;
    check("idle_no_window", VW'(win_cnt - cnt_base), VW'(0));

    // ramp frame, continuous input
    start_frame(1);
    send_frame(100, -1, -1);
    wait_done();
    check("ramp_c0",    got[0],    pack9(0,    0, 0, 0, 0, 0, 1, 0, 64, 65));
    check("ramp_c65",   got[65],   pack9(65,   0, 1, 2, 64, 65, 66, 128, 129, 130));
    check("ramp_c63",   got[63],   pack9(63,   0, 0, 0, 62, 63, 0, 126, 127, 0));
    check("ramp_c4095", got[4095], pack9(4095, 190, 191, 0, 254, 255, 0, 0, 0, 0));

    // back-to-back ramp frame at 50% input duty
    start_frame(1);
    send_frame(50, -1, -1);
    wait_done();
    check("b2b_c0", got[0], pack9(0, 0, 0, 0, 0, 0, 1, 0, 64, 65));

    // random frame, start poked mid-run
    start_frame(0);
    send_frame(70, 1000, -1);
    wait_done();

    // reset in the middle of a frame, then a full new frame
    start_frame(0);
    send_frame(100, -1, 2000);
    start_frame(0);
    send_frame(60, -1, -1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_stream_gen.md
# window_stream_gen

Upstream feeder for the layer-1 blur stage (Gaussian/median). Accepts one 64x64 8-bit frame as a raster-order pixel stream and emits, one per cycle, the zero-padded 3x3 neighbourhood of every pixel in raster order. The nine window outputs connect directly to the layer-1 filter's px_1..px_9 inputs. This replaces nine parallel pattern-memory reads with two line buffers and a single input port.

## Interface
- IMG_W, 64: frame width in pixels; power of two.
- IMG_H, 64: frame height in pixels; power of two.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle frame start request; honoured only in IDLE.
- in_valid  input  1  in_data holds a pixel.
- in_ready  output  1  block accepts a pixel this cycle; transfer = in_valid & in_ready.
- in_data  input  8  pixel in raster order, (0,0) first.
- win_valid  output  1  win_1..win_9 and win_addr are valid this cycle.
- win_1..win_9  output  8 each  window, row-major: 1-3 row y-1, 4-6 row y, 7-9 row y+1; left to right x-1, x, x+1.
- win_addr  output  12  center address {y[5:0], x[5:0]}.
- busy  output  1  high from the cycle after start is accepted until frame_done.
- frame_done  output  1  one-cycle pulse, coincident with the final window.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN on start. The tap shift register and counters clear on that edge.
- Tap store: 2*IMG_W+3 = 131 bytes. Each accepted pixel shifts in at tap 0.
- Taps: with newest pixel index n, the center is n-65. Row y-1 = taps 130,129,128. Row y = 66,65,64. Row y+1 = 2,1,0.
- RUN: in_ready=1. Accepted count n increments from 0 to 4095. Each accept with n>=65 registers window/addr for center n-65, win_valid=1. After accept of n=4095 -> FLUSH.
- FLUSH: in_ready=0. Shifts a zero byte in every cycle for 65 cycles, producing windows for centers 4031..4095. On the 65th cycle frame_done=1 and state -> IDLE.
- Padding by center coordinate, applied at output register load:
  - x=0 zeroes 1,4,7.
  - x=IMG_W-1 zeroes 3,6,9.
  - y=0 zeroes 1,2,3.
  - y=IMG_H-1 zeroes 7,8,9.
  - Corners combine both rules.
- No output backpressure; the consumer takes every win_valid cycle.
- start while busy: ignored. in_valid outside RUN: ignored, no accept.
- Counters: 12-bit pixel index, 7-bit flush counter. No wrap within a frame.

## Timing
- Reset values: in_ready=0, win_valid=0, win_1..win_9=0, win_addr=0, busy=0, frame_done=0. State IDLE; taps and counters zero.
- start at edge E: busy and in_ready high after E.
- Window latency: the window for center c appears one cycle after the accept of pixel c+65 (c<=4030), or during flush.
- win_valid is low in cycles without an accept during RUN. Gaps in in_valid reproduce as gaps in win_valid; data is unaffected.
- Continuous input: the last accept is at E0, frame_done at E0+65, busy low and state IDLE after E0+65. Exactly 4096 win_valid pulses per frame.
- Reset mid-frame: all outputs return to reset values immediately. No partial frame resumes. A new start is required.

## Test plan
- Ramp frame, pixel = addr[7:0], continuous: the center-0 window = 0,0,0,0,0,1,0,64,65, with win_addr=0 one cycle after pixel 65 accepted. Center 65 window = 0,1,2,64,65,66,128,129,130.
- Same frame, edges:
  - center 63 = 0,0,0,62,63,0,126,127,0.
  - center 4095 = 190,191,0,254,255,0,0,0,0, with frame_done=1 in the same cycle.
  - Count win_valid pulses = 4096.
- Random in_valid duty (50%): the window sequence matches the continuous run exactly. in_ready=0 during FLUSH. frame_done arrives 65 cycles after the last accept.
- start pulsed mid-RUN and in_valid asserted in IDLE: no state change, no accept, busy unaffected.
- reset asserted at pixel 2000: all outputs zero asynchronously. A new start plus a full frame yields the correct 4096 windows.
- Back-to-back frames: start in the cycle after frame_done. The second frame's center-0 window has zero padding with no residue from frame one.
